// File: rtl/mdu_pkg_r0.sv
// Shared definitions for the MIPS multiply/divide unit.
// Funct codes, FSM state encoding and funct classification helpers.
package mdu_pkg_r0;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
    endfunction

    // 0x18..0x1B: bit1 selects divide, bit0 selects unsigned.
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/mdu_datapath_r0.sv
// Shift-add multiply / restoring divide datapath with sign fixup.
// Ports: clk, rst (async low), load_i/div_i/sgn_i/a_i/b_i operand capture,
// step_mul_i/step_div_i iteration enables, hi_o/lo_o corrected results,
// mul_last_o early multiply completion (only with MDU_EARLY_TERM_EN).
module mdu_datapath_r0 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         div_i,
    input  logic         sgn_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         step_mul_i,
    input  logic         step_div_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic         mul_last_o
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_hi_q, neg_hi_d;
    logic           div_q, div_d;

    logic           sa, sb;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     part, diff;
    logic           ge;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;

    assign sa    = sgn_i & a_i[W-1];
    assign sb    = sgn_i & b_i[W-1];
    assign abs_a = sa ? -a_i : a_i;
    assign abs_b = sb ? -b_i : b_i;

    // Remainder shifted left with the next dividend bit brought in.
    assign part = acc_q[2*W-1:W-1];
    assign diff = part - {1'b0, opa_q[W-1:0]};
    assign ge   = part >= {1'b0, opa_q[W-1:0]};

    always_comb begin
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div_d    = div_q;
        if (load_i) begin
            div_d = div_i;
            opb_d = abs_b;
            opa_d = {{W{1'b0}}, abs_b};
            if (!div_i) begin
                acc_d    = '0;
                opa_d    = {{W{1'b0}}, abs_a};
                neg_lo_d = sa ^ sb;
                neg_hi_d = sa ^ sb;
            end else if (b_i == '0) begin
                // Quotient all ones; remainder re-signed back to rs.
                acc_d    = {abs_a, {W{1'b1}}};
                neg_lo_d = 1'b0;
                neg_hi_d = sa;
            end else begin
                acc_d    = {{W{1'b0}}, abs_a};
                neg_lo_d = sa ^ sb;
                neg_hi_d = sa;
            end
        end else if (step_mul_i) begin
            if (opb_q[0]) begin
                acc_d = acc_q + opa_q;
            end
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
        end else if (step_div_i) begin
            acc_d = {ge ? diff[W-1:0] : part[W-1:0],
                     acc_q[W-2:0], ge};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div_q    <= div_d;
        end
    end

    assign prod = neg_lo_q ? -acc_q : acc_q;
    assign quo  = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem  = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    assign hi_o = div_q ? rem : prod[2*W-1:W];
    assign lo_o = div_q ? quo : prod[W-1:0];

`ifdef MDU_EARLY_TERM_EN
    // No set multiplier bits left after this step.
    assign mul_last_o = opb_q[W-1:1] == '0;
`else
    assign mul_last_o = 1'b0;
`endif

endmodule

// File: rtl/mdu_controller_r0.sv
// Iterative MIPS multiply/divide sequencer with HI/LO registers.
// Ports: clk, rst (async low), valid/funct/rs_data/rt_data instruction in,
// flush abort, busy/stall pipeline control, result MFHI/MFLO data, hi/lo.
// Option: MDU_EARLY_TERM_EN ends multiplies once the multiplier runs out.
module mdu_controller_r0
    import mdu_pkg_r0::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic [FUNCT_WIDTH-1:0] funct,
    input  logic [DATA_WIDTH-1:0]  rs_data,
    input  logic [DATA_WIDTH-1:0]  rt_data,
    input  logic                   flush,
    output logic                   busy,
    output logic                   stall,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [DATA_WIDTH-1:0]  hi,
    output logic [DATA_WIDTH-1:0]  lo
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
        CNT_WIDTH'(DATA_WIDTH - 1);

    mdu_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic [5:0]            f6;
    logic                  load;
    logic                  mul_last, mul_done;
    logic [DATA_WIDTH-1:0] dp_hi, dp_lo;

    assign f6 = 6'(funct);

    mdu_datapath_r0 #(.W(DATA_WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .div_i      (f6[1]),
        .sgn_i      (~f6[0]),
        .a_i        (rs_data),
        .b_i        (rt_data),
        .step_mul_i (state_q == S_MUL),
        .step_div_i (state_q == S_DIV),
        .hi_o       (dp_hi),
        .lo_o       (dp_lo),
        .mul_last_o (mul_last)
    );

    assign mul_done = (cnt_q == '0) | mul_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        case (f6)
                            FUNCT_MTHI: hi_d = rs_data;
                            FUNCT_MTLO: lo_d = rs_data;
                            FUNCT_MULT, FUNCT_MULTU: begin
                                load    = 1'b1;
                                cnt_d   = CNT_LOAD;
                                state_d = S_MUL;
                            end
                            FUNCT_DIV, FUNCT_DIVU: begin
                                load    = 1'b1;
                                cnt_d   = CNT_LOAD;
                                state_d = (rt_data == '0) ?
                                          S_FIX : S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (mul_done) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
                S_DIV: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    hi_d    = dp_hi;
                    lo_d    = dp_lo;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = state_q != S_IDLE;
    assign stall = valid & busy & is_mdu_funct(f6);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        result = '0;
        if (valid && f6 == FUNCT_MFHI) begin
            result = hi_q;
        end else if (valid && f6 == FUNCT_MFLO) begin
            result = lo_q;
        end
    end

    // Only the mul/div group is consumed by the datapath decode.
    logic unused_ok;
    assign unused_ok = is_muldiv(f6);

endmodule

// File: tb/tb_mdu_controller_r0.sv
// Directed self-checking bench for mdu_controller_r0.
// Vector table for arithmetic plus sequences for stall, flush and reset.
module tb_mdu_controller_r0;

`ifdef MDU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data;
    logic        flush;
    logic        busy, stall;
    logic [31:0] result, hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    mdu_controller_r0 dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .funct   (funct),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .result  (result),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int mul_busy(input logic [5:0] f,
                                    input logic [31:0] b);
        logic [31:0] m;
        int it;
        m  = (f == 6'h18 && b[31]) ? -b : b;
        it = 1;
        for (int k = 0; k < 32; k++) if (m[k]) it = k + 1;
        return EARLY ? it + 1 : 33;
    endfunction

    function automatic int exp_busy(input logic [5:0] f,
                                    input logic [31:0] b);
        if (f[1]) return (b == 0) ? 1 : 33;
        return mul_busy(f, b);
    endfunction

    // Called at a negedge; returns at the negedge after the issue edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        valid   = 1'b1;
        funct   = f;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        valid = 1'b0;
        funct = 6'h00;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{6'h18, 32'hFFFFFFFD, 32'd7,
                   32'hFFFFFFFF, 32'hFFFFFFEB};
        tv[1]  = '{6'h19, 32'hFFFFFFFF, 32'd2,
                   32'h00000001, 32'hFFFFFFFE};
        tv[2]  = '{6'h1A, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[3]  = '{6'h1B, 32'd100, 32'd7, 32'd2, 32'd14};
        tv[4]  = '{6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
        tv[5]  = '{6'h19, 32'd5, 32'd3, 32'd0, 32'd15};
        tv[6]  = '{6'h18, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h0};
        tv[7]  = '{6'h1B, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF};
        tv[8]  = '{6'h1A, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        tv[9]  = '{6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
        tv[10] = '{6'h1A, 32'hFFFFFFFB, 32'd0,
                   32'hFFFFFFFB, 32'hFFFFFFFF};
        tv[11] = '{6'h18, 32'h12345678, 32'd0, 32'd0, 32'd0};
        tv[12] = '{6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1};
        tv[13] = '{6'h18, 32'd2, 32'hFFFFFFFD,
                   32'hFFFFFFFF, 32'hFFFFFFFA};

        rst = 1'b0; valid = 1'b0; funct = '0;
        rs_data = '0; rt_data = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // MTHI then MFHI in the following cycle
        valid = 1'b1; funct = 6'h11; rs_data = 32'hDEADBEEF;
        @(negedge clk);
        funct = 6'h10;
        #1;
        chk("mfhi_result", {32'd0, result}, {32'd0, 32'hDEADBEEF});
        chk("mfhi_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        valid = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(tv[i].f, tv[i].a, tv[i].b);
            wait_busy(n);
            chk($sformatf("vec%0d_busy", i), 64'(n),
                64'(exp_busy(tv[i].f, tv[i].b)));
            chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, tv[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, tv[i].lo});
        end

        // MULT, an ADD in the shadow, then MFLO waiting on the product
        issue(6'h18, 32'hFFFFFFFD, 32'd7);
        valid = 1'b1; funct = 6'h20;
        #1;
        chk("add_no_stall", {63'd0, stall}, 64'd0);
        chk("add_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        funct = 6'h12;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mflo_stall_cycles", 64'(n),
            64'(mul_busy(6'h18, 32'd7) - 1));
        chk("mflo_busy_low", {63'd0, busy}, 64'd0);
        chk("mflo_result", {32'd0, result}, {32'd0, 32'hFFFFFFEB});
        @(negedge clk);
        valid = 1'b0;

        // back-to-back: DIVU held behind MULTU
        valid = 1'b1; funct = 6'h19; rs_data = 32'd5; rt_data = 32'd3;
        @(negedge clk);
        funct = 6'h1B; rs_data = 32'd100; rt_data = 32'd7;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("b2b_stall_cycles", 64'(n), 64'(mul_busy(6'h19, 32'd3)));
        chk("b2b_first_lo", {32'd0, lo}, 64'd15);
        @(negedge clk);
        valid = 1'b0;
        wait_busy(n);
        chk("b2b_div_busy", 64'(n), 64'd33);
        chk("b2b_div_hi", {32'd0, hi}, 64'd2);
        chk("b2b_div_lo", {32'd0, lo}, 64'd14);

        // MTHI while busy stalls and leaves the divide result intact
        issue(6'h1B, 32'd50, 32'd7);
        valid = 1'b1; funct = 6'h11; rs_data = 32'hAAAA;
        #1;
        chk("mthi_busy_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        valid = 1'b0;
        wait_busy(n);
        chk("mthi_busy_hi", {32'd0, hi}, 64'd1);
        chk("mthi_busy_lo", {32'd0, lo}, 64'd7);

        // flush mid-divide keeps prior HI/LO
        issue(6'h11, 32'h11, 32'd0);
        issue(6'h13, 32'h22, 32'd0);
        issue(6'h1B, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hi", {32'd0, hi}, 64'h11);
        chk("flush_lo", {32'd0, lo}, 64'h22);

        // flush beats a same-cycle MULT
        valid = 1'b1; funct = 6'h18; rs_data = 32'd3; rt_data = 32'd4;
        flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        chk("flush_mult_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("flush_mult_lo", {32'd0, lo}, 64'h22);

        // asynchronous reset in the middle of a multiply
        issue(6'h18, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(6'h19, 32'd5, 32'd3);
        wait_busy(n);
        chk("post_rst_busy", 64'(n), 64'(mul_busy(6'h19, 32'd3)));
        chk("post_rst_lo", {32'd0, lo}, 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
